// File: rtl/bk_memarb_pkg.sv
// Shared types and widths for the BK-0010 shared-SRAM arbiter.
package bk_memarb_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int VID_AW  = 13;

  localparam logic [SRAM_AW-1:0] VIDEO_BASE_DEFAULT = 18'h02000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID_RD  = 3'd1,
    ST_CPU_RD  = 3'd2,
    ST_CPU_WR  = 3'd3,
    ST_WR_HOLD = 3'd4
  } arb_state_e;

endpackage

// File: rtl/bk_mem_arbiter.sv
// Merges the CPU port and the video word fetch onto one asynchronous 16-bit SRAM.
// Define BK_MEMARB_OVERRUN_CNT_EN to build the saturating video overrun counter.
module bk_mem_arbiter
  import bk_memarb_pkg::*;
#(
  parameter int                  ACCESS_CYCLES = 2,
  parameter logic [SRAM_AW-1:0]  VIDEO_BASE    = VIDEO_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [SRAM_AW-1:0] cpu_addr,
  input  logic               cpu_lb_n,
  input  logic               cpu_ub_n,
  input  logic [SRAM_DW-1:0] cpu_wdata,
  output logic [SRAM_DW-1:0] cpu_rdata,
  output logic               cpu_ack,
  input  logic               vid_req,
  input  logic [VID_AW-1:0]  vid_addr,
  output logic [SRAM_DW-1:0] vid_data,
  output logic               vid_valid,
  output logic               membusy,
  output logic [7:0]         vid_overrun_cnt,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic               sram_ce_n
);

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_d;
  logic [2:0]         r_cnt;
  logic               r_vid_pend;
  logic [VID_AW-1:0]  r_vid_addr;
  logic               r_armed;
  logic               r_cpu_lb_n;
  logic               r_cpu_ub_n;

  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_sram_dq_o;
  logic               r_sram_dq_oe;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_lb_n;
  logic               r_ub_n;
  logic               r_cpu_ack;
  logic [SRAM_DW-1:0] r_cpu_rdata;
  logic [SRAM_DW-1:0] r_vid_data;
  logic               r_vid_valid;
  logic               r_membusy;

  logic               w_last;
  logic               w_strobe;
  logic               w_vid_done;
  logic               w_cpu_done;
  logic               w_vid_go;
  logic               w_grant;
  logic               w_vid_pend_d;
  logic [VID_AW-1:0]  w_vid_addr_d;
  logic               w_cpu_lb_n_d;
  logic               w_cpu_ub_n_d;
  logic [SRAM_AW-1:0] w_sram_addr_d;
  logic [SRAM_DW-1:0] w_sram_dq_o_d;
  logic               w_sram_dq_oe_d;
  logic               w_oe_n_d;
  logic               w_we_n_d;
  logic               w_lb_n_d;
  logic               w_ub_n_d;

  assign w_last       = (r_cnt == LAST_CNT);
  assign w_strobe     = (r_state == ST_VID_RD) || (r_state == ST_CPU_RD) || (r_state == ST_CPU_WR);
  assign w_vid_done   = (r_state == ST_VID_RD) && w_last;
  assign w_cpu_done   = ((r_state == ST_CPU_RD) && w_last) || (r_state == ST_WR_HOLD);
  // A fetch pulse in the IDLE cycle itself is served without waiting for vid_pend.
  assign w_vid_go     = r_vid_pend || vid_req;
  assign w_grant      = (r_state == ST_IDLE) && !w_vid_go && cpu_req && r_armed;
  assign w_vid_addr_d = vid_req ? vid_addr : r_vid_addr;
  assign w_cpu_lb_n_d = w_grant ? cpu_lb_n : r_cpu_lb_n;
  assign w_cpu_ub_n_d = w_grant ? cpu_ub_n : r_cpu_ub_n;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: video first, granted accesses always run to completion
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_vid_go) begin
          w_state_d = ST_VID_RD;
        end else if (w_grant) begin
          w_state_d = cpu_we ? ST_CPU_WR : ST_CPU_RD;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      ST_VID_RD:  w_state_d = w_last ? ST_IDLE : ST_VID_RD;
      ST_CPU_RD:  w_state_d = w_last ? ST_IDLE : ST_CPU_RD;
      ST_CPU_WR:  w_state_d = w_last ? ST_WR_HOLD : ST_CPU_WR;
      ST_WR_HOLD: w_state_d = ST_IDLE;
      default:    w_state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state
  always_comb begin
    w_oe_n_d       = 1'b1;
    w_we_n_d       = 1'b1;
    w_sram_dq_oe_d = 1'b0;
    w_lb_n_d       = 1'b1;
    w_ub_n_d       = 1'b1;
    case (w_state_d)
      ST_VID_RD: begin
        w_oe_n_d = 1'b0;
        w_lb_n_d = 1'b0;
        w_ub_n_d = 1'b0;
      end
      ST_CPU_RD: begin
        w_oe_n_d = 1'b0;
        w_lb_n_d = w_cpu_lb_n_d;
        w_ub_n_d = w_cpu_ub_n_d;
      end
      ST_CPU_WR: begin
        w_we_n_d       = 1'b0;
        w_sram_dq_oe_d = 1'b1;
        w_lb_n_d       = w_cpu_lb_n_d;
        w_ub_n_d       = w_cpu_ub_n_d;
      end
      ST_WR_HOLD: begin
        w_sram_dq_oe_d = 1'b1;
        w_lb_n_d       = w_cpu_lb_n_d;
        w_ub_n_d       = w_cpu_ub_n_d;
      end
      default: begin
        w_oe_n_d = 1'b1;
      end
    endcase
    // Address is loaded only on leaving IDLE so it stays stable for the whole access.
    if ((r_state == ST_IDLE) && (w_state_d == ST_VID_RD)) begin
      w_sram_addr_d = VIDEO_BASE + {{(SRAM_AW-VID_AW){1'b0}}, w_vid_addr_d};
    end else if (w_grant) begin
      w_sram_addr_d = cpu_addr;
    end else begin
      w_sram_addr_d = r_sram_addr;
    end
    if (w_grant) begin
      w_sram_dq_o_d = cpu_wdata;
    end else begin
      w_sram_dq_o_d = r_sram_dq_o;
    end
  end

  // Pending-fetch flag: a new pulse wins over completion
  always_comb begin
    if (vid_req) begin
      w_vid_pend_d = 1'b1;
    end else if (w_vid_done) begin
      w_vid_pend_d = 1'b0;
    end else begin
      w_vid_pend_d = r_vid_pend;
    end
  end

  // Strobe-length counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 3'd0;
    end else if (w_strobe && !w_last) begin
      r_cnt <= r_cnt + 3'd1;
    end else begin
      r_cnt <= 3'd0;
    end
  end

  // Video request capture and CPU re-arm tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_pend <= 1'b0;
      r_vid_addr <= '0;
      r_armed    <= 1'b1;
      r_cpu_lb_n <= 1'b1;
      r_cpu_ub_n <= 1'b1;
    end else begin
      r_vid_pend <= w_vid_pend_d;
      r_vid_addr <= w_vid_addr_d;
      r_cpu_lb_n <= w_cpu_lb_n_d;
      r_cpu_ub_n <= w_cpu_ub_n_d;
      if (w_cpu_done) begin
        r_armed <= 1'b0;
      end else if (!cpu_req) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Registered SRAM bus and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sram_addr  <= '0;
      r_sram_dq_o  <= '0;
      r_sram_dq_oe <= 1'b0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_cpu_ack    <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_membusy    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_vid_data   <= '0;
    end else begin
      r_sram_addr  <= w_sram_addr_d;
      r_sram_dq_o  <= w_sram_dq_o_d;
      r_sram_dq_oe <= w_sram_dq_oe_d;
      r_oe_n       <= w_oe_n_d;
      r_we_n       <= w_we_n_d;
      r_lb_n       <= w_lb_n_d;
      r_ub_n       <= w_ub_n_d;
      r_cpu_ack    <= w_cpu_done;
      r_vid_valid  <= w_vid_done;
      r_membusy    <= w_vid_pend_d || (r_state == ST_VID_RD);
      r_cpu_rdata  <= ((r_state == ST_CPU_RD) && w_last) ? sram_dq_i : r_cpu_rdata;
      r_vid_data   <= w_vid_done ? sram_dq_i : r_vid_data;
    end
  end

`ifdef BK_MEMARB_OVERRUN_CNT_EN
  logic       w_overrun;
  logic [7:0] r_ovr_cnt;

  assign w_overrun = vid_req && r_vid_pend && !w_vid_done;

  // Saturating overrun counter, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= 8'd0;
    end else if (w_overrun && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end else begin
      r_ovr_cnt <= r_ovr_cnt;
    end
  end

  assign vid_overrun_cnt = r_ovr_cnt;
`else
  assign vid_overrun_cnt = 8'h00;
`endif

  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_sram_dq_oe;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_ce_n  = 1'b0;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_rdata;
  assign vid_data   = r_vid_data;
  assign vid_valid  = r_vid_valid;
  assign membusy    = r_membusy;

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Self-checking bench for bk_mem_arbiter: vector table, directed corner sequences,
// and randomized transactions against a transaction-level timing/memory model.
module tb_bk_mem_arbiter;
  import bk_memarb_pkg::*;

  localparam int AC = 2;
  localparam logic [17:0] VBASE = 18'h02000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lb_n = 1'b1, cpu_ub_n = 1'b1;
  logic [17:0] cpu_addr = 18'h0;
  logic [15:0] cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = 13'h0;
  logic [15:0] vid_data;
  logic        vid_valid, membusy;
  logic [7:0]  vid_overrun_cnt;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_ce_n;

  bk_mem_arbiter #(.ACCESS_CYCLES(AC), .VIDEO_BASE(VBASE)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_lb_n(cpu_lb_n), .cpu_ub_n(cpu_ub_n), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .membusy(membusy), .vid_overrun_cnt(vid_overrun_cnt),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .sram_ce_n(sram_ce_n)
  );

  always #20 clk = ~clk;

  // SRAM model with a preload port so the array has a single writer
  logic [15:0] mem [0:262143];
  logic [15:0] ref_mem [0:262143];
  logic        pk_en = 1'b0;
  logic [17:0] pk_addr = 18'h0;
  logic [15:0] pk_data = 16'h0;

  assign sram_dq_i = mem[sram_addr];

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (!sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [15:0] d);
    pk_addr = a; pk_data = d; pk_en = 1'b1;
    @(posedge clk); #1;
    pk_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Stimulus description for one sequence and its per-cycle trace
  int          cpu_at;
  logic        s_we, s_lb, s_ub;
  logic [17:0] s_addr;
  logic [15:0] s_wd;
  int          vid_at [2];
  logic [12:0] vid_off [2];

  logic        tr_oe [16], tr_we [16], tr_dqoe [16], tr_busy [16], tr_lb [16], tr_ub [16];
  logic [17:0] tr_addr [16];
  logic [15:0] tr_rd [16], tr_vd [16], tr_dqo [16];
  int          ack_cyc, val_cyc, n_ack, n_val, n_oe;

  task automatic clear_stim();
    cpu_at = -1; vid_at[0] = -1; vid_at[1] = -1;
    s_we = 1'b0; s_lb = 1'b0; s_ub = 1'b0; s_addr = 18'h0; s_wd = 16'h0;
    vid_off[0] = 13'h0; vid_off[1] = 13'h0;
  endtask

  task automatic set_cpu(input logic we, input logic [17:0] a, input logic lb, input logic ub,
                         input logic [15:0] wd);
    cpu_at = 0; s_we = we; s_addr = a; s_lb = lb; s_ub = ub; s_wd = wd;
  endtask

  // Entered and left just after a rising edge; cycle 0 is the first driven cycle
  task automatic run_seq(input int n);
    bit acked;
    acked = 1'b0;
    ack_cyc = -1; val_cyc = -1; n_ack = 0; n_val = 0; n_oe = 0;
    for (int c = 0; c < n; c++) begin
      cpu_req   = (cpu_at >= 0 && c >= cpu_at && !acked) ? 1'b1 : 1'b0;
      cpu_we    = s_we; cpu_addr = s_addr; cpu_lb_n = s_lb; cpu_ub_n = s_ub; cpu_wdata = s_wd;
      vid_req   = 1'b0; vid_addr = 13'h0;
      for (int k = 0; k < 2; k++) begin
        if (vid_at[k] == c) begin vid_req = 1'b1; vid_addr = vid_off[k]; end
      end
      @(negedge clk);
      tr_oe[c] = sram_oe_n; tr_we[c] = sram_we_n; tr_dqoe[c] = sram_dq_oe; tr_busy[c] = membusy;
      tr_lb[c] = sram_lb_n; tr_ub[c] = sram_ub_n; tr_addr[c] = sram_addr;
      tr_rd[c] = cpu_rdata; tr_vd[c] = vid_data; tr_dqo[c] = sram_dq_o;
      if (cpu_ack) begin acked = 1'b1; n_ack++; if (ack_cyc < 0) ack_cyc = c; end
      if (vid_valid) begin n_val++; if (val_cyc < 0) val_cyc = c; end
      if (!sram_oe_n) n_oe++;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  typedef struct {
    logic        is_vid;
    logic        we;
    logic [17:0] addr;
    logic        lb_n;
    logic        ub_n;
    logic [15:0] wd;
    logic [12:0] voff;
    int          exp_lat;
    logic [17:0] exp_saddr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, mode;
    logic [15:0] act, exp_v, exp_c;
    logic [12:0] r_off;

    vecs[0] = '{1'b0, 1'b1, 18'h00010, 1'b0, 1'b0, 16'hA5A5, 13'h0000, 4, 18'h00010, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b1, 18'h00010, 1'b1, 1'b0, 16'h7E11, 13'h0000, 4, 18'h00010, 16'h7EA5};
    vecs[2] = '{1'b0, 1'b0, 18'h00010, 1'b0, 1'b0, 16'h0000, 13'h0000, 3, 18'h00010, 16'h7EA5};
    vecs[3] = '{1'b0, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 16'h0000, 13'h0000, 3, 18'h3FFFF, 16'hC0DE};
    vecs[4] = '{1'b0, 1'b1, 18'h3FFFF, 1'b0, 1'b1, 16'h0001, 13'h0000, 4, 18'h3FFFF, 16'hC001};
    vecs[5] = '{1'b0, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 16'h0000, 13'h0000, 3, 18'h3FFFF, 16'hC001};
    vecs[6] = '{1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 16'h0000, 13'h1FFF, 3, 18'h03FFF, 16'h9999};
    vecs[7] = '{1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 16'h0000, 13'h0000, 3, 18'h02000, 16'h4444};

    // Reset values
    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_ce_n, sram_dq_oe}, 6'b111100);
    chk("rst_addr", sram_addr, 18'h0);
    chk("rst_pulses", {cpu_ack, vid_valid, membusy}, 3'b000);
    chk("rst_rdata", cpu_rdata, 16'h0);
    chk("rst_vdata", vid_data, 16'h0);
    chk("rst_ovr", vid_overrun_cnt, 8'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, each transaction from idle
    poke(18'h3FFFF, 16'hC0DE); poke(18'h03FFF, 16'h9999);
    poke(18'h02000, 16'h4444); poke(18'h00010, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      clear_stim();
      if (vecs[i].is_vid) begin
        vid_at[0] = 0; vid_off[0] = vecs[i].voff;
      end else begin
        set_cpu(vecs[i].we, vecs[i].addr, vecs[i].lb_n, vecs[i].ub_n, vecs[i].wd);
      end
      run_seq(8);
      lat = vecs[i].is_vid ? val_cyc : ack_cyc;
      act = vecs[i].is_vid ? vid_data : (vecs[i].we ? mem[vecs[i].addr] : cpu_rdata);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_addr", i), tr_addr[1], vecs[i].exp_saddr);
      chk($sformatf("vec%0d_data", i), act, vecs[i].exp_data);
      chk($sformatf("vec%0d_pulses", i), vecs[i].is_vid ? n_val : n_ack, 1);
    end

    // Idle CPU read
    poke(18'h00100, 16'h1234);
    clear_stim(); set_cpu(1'b0, 18'h00100, 1'b0, 1'b0, 16'h0);
    run_seq(8);
    chk("s1_oe_cnt", n_oe, 2);
    chk("s1_oe_win", {tr_oe[0], tr_oe[1], tr_oe[2], tr_oe[3]}, 4'b1001);
    chk("s1_ack_cyc", ack_cyc, 3);
    chk("s1_rdata", tr_rd[3], 16'h1234);
    chk("s1_n_ack", n_ack, 1);
    chk("s1_addr", tr_addr[1], 18'h00100);

    // Low-byte write
    poke(18'h00200, 16'h5566);
    clear_stim(); set_cpu(1'b1, 18'h00200, 1'b0, 1'b1, 16'hABCD);
    run_seq(8);
    chk("s2_we_win", {tr_we[0], tr_we[1], tr_we[2], tr_we[3]}, 4'b1001);
    chk("s2_hold_drv", {tr_dqoe[3], tr_dqo[3]}, {1'b1, 16'hABCD});
    chk("s2_bytes", {tr_lb[1], tr_ub[1]}, 2'b01);
    chk("s2_ack_cyc", ack_cyc, 4);
    chk("s2_release", tr_dqoe[5], 1'b0);
    chk("s2_mem", mem[18'h00200], 16'h55CD);

    // Simultaneous video and CPU read
    poke(18'h02005, 16'hBEEF);
    clear_stim(); set_cpu(1'b0, 18'h00100, 1'b0, 1'b0, 16'h0);
    vid_at[0] = 0; vid_off[0] = 13'h0005;
    run_seq(10);
    chk("s3_vaddr", tr_addr[1], 18'h02005);
    chk("s3_val_cyc", val_cyc, 3);
    chk("s3_vdata", tr_vd[3], 16'hBEEF);
    chk("s3_ack_cyc", ack_cyc, 6);
    chk("s3_rdata", tr_rd[6], 16'h1234);
    chk("s3_busy", {tr_busy[0], tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4]}, 5'b01110);
    chk("s3_caddr", tr_addr[4], 18'h00100);

    // Video request during a CPU write
    poke(18'h02007, 16'h7777);
    clear_stim(); set_cpu(1'b1, 18'h00300, 1'b0, 1'b0, 16'h1111);
    vid_at[0] = 2; vid_off[0] = 13'h0007;
    run_seq(12);
    chk("s4_ack_cyc", ack_cyc, 4);
    chk("s4_wr_addr", tr_addr[3], 18'h00300);
    chk("s4_mem", mem[18'h00300], 16'h1111);
    chk("s4_vid_start", {tr_oe[4], tr_oe[5]}, 2'b10);
    chk("s4_vaddr", tr_addr[5], 18'h02007);
    chk("s4_val", {val_cyc[7:0], tr_vd[7]}, {8'd7, 16'h7777});
    chk("s4_busy", tr_busy[3], 1'b1);

    // Two video pulses during one CPU read: newest address wins
    poke(18'h02001, 16'h1001); poke(18'h02002, 16'h2002);
    clear_stim(); set_cpu(1'b0, 18'h00100, 1'b0, 1'b0, 16'h0);
    vid_at[0] = 1; vid_off[0] = 13'h0001;
    vid_at[1] = 2; vid_off[1] = 13'h0002;
    run_seq(12);
`ifdef BK_MEMARB_OVERRUN_CNT_EN
    exp_ovr = exp_ovr + 1;
`endif
    chk("s5_ack_cyc", ack_cyc, 3);
    chk("s5_n_val", n_val, 1);
    chk("s5_val_cyc", val_cyc, 6);
    chk("s5_vaddr", tr_addr[4], 18'h02002);
    chk("s5_vdata", tr_vd[6], 16'h2002);
    chk("s5_ovr", vid_overrun_cnt, exp_ovr);

    // Randomized transactions against the transaction-level model
    for (int i = 0; i < 16; i++) begin
      poke(VBASE + 18'(i), 16'($urandom));
      poke(18'h00100 + 18'(i), 16'($urandom));
    end
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      clear_stim();
      r_off = 13'($urandom_range(0, 15));
      set_cpu(1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0 ? VBASE : 18'h00100) + 18'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      if (mode == 1) cpu_at = -1;
      if (mode != 0) begin vid_at[0] = 0; vid_off[0] = r_off; end
      exp_v = ref_mem[VBASE + {5'b0, r_off}];
      exp_c = ref_mem[s_addr];
      run_seq(12);
      if (mode != 0) begin
        chk("rnd_val_cyc", val_cyc, AC + 1);
        chk("rnd_vdata", vid_data, exp_v);
        chk("rnd_vaddr", tr_addr[1], VBASE + {5'b0, r_off});
      end else begin
        chk("rnd_no_val", n_val, 0);
      end
      if (mode != 1) begin
        chk("rnd_ack_cyc", ack_cyc, (mode == 2 ? AC + 1 : 0) + (s_we ? AC + 2 : AC + 1));
        chk("rnd_n_ack", n_ack, 1);
        if (s_we) begin
          if (!s_lb) exp_c[7:0] = s_wd[7:0];
          if (!s_ub) exp_c[15:8] = s_wd[15:8];
          ref_mem[s_addr] = exp_c;
          chk("rnd_wmem", mem[s_addr], exp_c);
        end else begin
          chk("rnd_rdata", cpu_rdata, exp_c);
        end
      end else begin
        chk("rnd_no_ack", n_ack, 0);
      end
    end

    // Reset in the middle of a write
    clear_stim();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00400; cpu_lb_n = 1'b0; cpu_ub_n = 1'b0;
    cpu_wdata = 16'h2222;
    @(posedge clk); #1;
    chk("s6_we_pre", sram_we_n, 1'b0);
    #5 reset_n = 1'b0;
    #1;
    chk("s6_rst_bus", {sram_we_n, sram_dq_oe, sram_oe_n}, 3'b101);
    chk("s6_rst_addr", sram_addr, 18'h0);
    cpu_req = 1'b0;
    exp_ovr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    chk("s6_no_ack", n_ack, 0);
    chk("s6_ovr", vid_overrun_cnt, exp_ovr);
    chk("s6_rdata", cpu_rdata, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
